// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and load-use hazard unit for the pipelined MIPS core.
//   Computes a registered per-port EX operand forward select and a
//   combinational one-cycle load-use stall controlled by a RUN/BUBBLE FSM.
//
//   Optional feature macro: FWD_STATS_EN
//     defined   -> saturating forward-event and stall-cycle counters
//     undefined -> o_stat_fwd / o_stat_stall tied to zero, no counters built
//
// Ports:
//   clk             core clock, all state updates on posedge
//   rst_n           synchronous active-low reset
//   i_ex_src        EX source register numbers, port i = [i*AW +: AW]
//   i_id_src        ID source register numbers (load-use check)
//   i_ex_rd         EX destination register
//   i_ex_memread    EX instruction is a load
//   i_mem_rd        MEM destination register
//   i_mem_regwrite  MEM instruction writes the register file
//   i_wb_rd         WB destination register
//   i_wb_regwrite   WB instruction writes the register file
//   o_fwd_sel       registered forward select, port i = [2i +: 2]
//                   (00 regfile, 10 from MEM, 01 from WB)
//   o_stall         hold PC and IF/ID, bubble into ID/EX
//   o_stat_fwd      saturating forward-event count (FWD_STATS_EN)
//   o_stat_stall    saturating stall-cycle count (FWD_STATS_EN)
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter int AW     = 5,
  parameter int NPORTS = 2,
  parameter int CNTW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NPORTS*AW-1:0]   i_ex_src,
  input  logic [NPORTS*AW-1:0]   i_id_src,
  input  logic [AW-1:0]          i_ex_rd,
  input  logic                   i_ex_memread,
  input  logic [AW-1:0]          i_mem_rd,
  input  logic                   i_mem_regwrite,
  input  logic [AW-1:0]          i_wb_rd,
  input  logic                   i_wb_regwrite,
  output logic [2*NPORTS-1:0]    o_fwd_sel,
  output logic                   o_stall,
  output logic [CNTW-1:0]        o_stat_fwd,
  output logic [CNTW-1:0]        o_stat_stall
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t               r_state;
  logic [2*NPORTS-1:0]  r_fwd_sel;
  logic [2*NPORTS-1:0]  w_fwd_sel_next;
  logic                 w_hazard;
  logic                 w_mem_ok;
  logic                 w_wb_ok;
  logic                 w_load_ok;

  // Producer qualification: a write to register zero is never a real producer.
  always_comb begin
    w_mem_ok  = i_mem_regwrite && (i_mem_rd != {AW{1'b0}});
    w_wb_ok   = i_wb_regwrite  && (i_wb_rd  != {AW{1'b0}});
    w_load_ok = i_ex_memread   && (i_ex_rd  != {AW{1'b0}});
  end

  // Per-port forward select (MEM beats WB as it holds the newer value) and load-use detect.
  always_comb begin
    w_fwd_sel_next = {(2*NPORTS){1'b0}};
    w_hazard       = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (w_mem_ok && (i_mem_rd == i_ex_src[i*AW +: AW])) begin
        w_fwd_sel_next[2*i +: 2] = 2'b10;
      end else if (w_wb_ok && (i_wb_rd == i_ex_src[i*AW +: AW])) begin
        w_fwd_sel_next[2*i +: 2] = 2'b01;
      end else begin
        w_fwd_sel_next[2*i +: 2] = 2'b00;
      end
      if (w_load_ok && (i_ex_rd == i_id_src[i*AW +: AW])) begin
        w_hazard = 1'b1;
      end else begin
        w_hazard = w_hazard;
      end
    end
  end

  // Forward-select register and RUN/BUBBLE stall FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_fwd_sel <= {(2*NPORTS){1'b0}};
    end else begin
      r_fwd_sel <= w_fwd_sel_next;
      case (r_state)
        ST_RUN:    r_state <= w_hazard ? ST_BUBBLE : ST_RUN;
        ST_BUBBLE: r_state <= ST_RUN;
        default:   r_state <= ST_RUN;
      endcase
    end
  end

  // Stall is same-cycle; BUBBLE masks the hazard so one load stalls at most one cycle.
  always_comb begin
    if (!rst_n) begin
      o_stall = 1'b0;
    end else if (r_state == ST_RUN) begin
      o_stall = w_hazard;
    end else begin
      o_stall = 1'b0;
    end
  end

  assign o_fwd_sel = r_fwd_sel;

`ifdef FWD_STATS_EN
  logic [CNTW-1:0] r_stat_fwd;
  logic [CNTW-1:0] r_stat_stall;

  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_fwd   <= {CNTW{1'b0}};
      r_stat_stall <= {CNTW{1'b0}};
    end else begin
      if ((|w_fwd_sel_next) && (r_stat_fwd != {CNTW{1'b1}})) begin
        r_stat_fwd <= r_stat_fwd + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        r_stat_fwd <= r_stat_fwd;
      end
      if (o_stall && (r_stat_stall != {CNTW{1'b1}})) begin
        r_stat_stall <= r_stat_stall + {{(CNTW-1){1'b0}}, 1'b1};
      end else begin
        r_stat_stall <= r_stat_stall;
      end
    end
  end

  assign o_stat_fwd   = r_stat_fwd;
  assign o_stat_stall = r_stat_stall;
`else
  assign o_stat_fwd   = {CNTW{1'b0}};
  assign o_stat_stall = {CNTW{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int AW     = 5;
  localparam int NPORTS = 2;
  localparam int CNTW   = 4;

`ifdef FWD_STATS_EN
  localparam logic [CNTW-1:0] EXP_SAT_FWD   = 4'd15;
  localparam logic [CNTW-1:0] EXP_ONE_STALL = 4'd1;
`else
  localparam logic [CNTW-1:0] EXP_SAT_FWD   = 4'd0;
  localparam logic [CNTW-1:0] EXP_ONE_STALL = 4'd0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic [NPORTS*AW-1:0] ex_src;
  logic [NPORTS*AW-1:0] id_src;
  logic [AW-1:0]        ex_rd;
  logic                 ex_memread;
  logic [AW-1:0]        mem_rd;
  logic                 mem_regwrite;
  logic [AW-1:0]        wb_rd;
  logic                 wb_regwrite;
  logic [2*NPORTS-1:0]  fwd_sel;
  logic                 stall;
  logic [CNTW-1:0]      stat_fwd;
  logic [CNTW-1:0]      stat_stall;

  int checks = 0;
  int errors = 0;

  fwd_hazard_unit #(.AW(AW), .NPORTS(NPORTS), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_ex_src       (ex_src),
    .i_id_src       (id_src),
    .i_ex_rd        (ex_rd),
    .i_ex_memread   (ex_memread),
    .i_mem_rd       (mem_rd),
    .i_mem_regwrite (mem_regwrite),
    .i_wb_rd        (wb_rd),
    .i_wb_regwrite  (wb_regwrite),
    .o_fwd_sel      (fwd_sel),
    .o_stall        (stall),
    .o_stat_fwd     (stat_fwd),
    .o_stat_stall   (stat_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] ex_src;
    logic [9:0] id_src;
    logic [4:0] ex_rd;
    logic       memread;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic [3:0] exp_fwd;
    logic       exp_stall;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ex_src = 10'd0; id_src = 10'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
  endtask

  initial begin
    // ex_src/id_src written as {port1, port0}
    vecs[0]  = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{{5'd2, 5'd1}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0, 4'b0010, 1'b0};
    vecs[2]  = '{{5'd2, 5'd1}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 4'b0110, 1'b0};
    vecs[3]  = '{{5'd0, 5'd3}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd3, 1'b1, 5'd3, 1'b1, 4'b0010, 1'b0};
    vecs[4]  = '{{5'd0, 5'd3}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd3, 1'b0, 5'd3, 1'b1, 4'b0001, 1'b0};
    vecs[5]  = '{{5'd7, 5'd7}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 4'b1010, 1'b0};
    vecs[6]  = '{{5'd9, 5'd9}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd9, 1'b0, 5'd9, 1'b1, 4'b0101, 1'b0};
    vecs[7]  = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 4'b0000, 1'b0};
    vecs[8]  = '{{5'd5, 5'd5}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd6, 1'b1, 5'd5, 1'b0, 4'b0000, 1'b0};
    vecs[9]  = '{{5'd0, 5'd0}, {5'd0, 5'd4}, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b1};
    vecs[10] = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vecs[11] = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};
    vecs[12] = '{{5'd0, 5'd0}, {5'd8, 5'd8}, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'b0000, 1'b0};

    clear_inputs();
    rst_n = 1'b0;

    // Reset for 2 cycles with a live load-use hazard: stall must stay low.
    ex_memread = 1'b1; ex_rd = 5'd4; id_src = {5'd4, 5'd0};
    mem_rd = 5'd1; mem_regwrite = 1'b1; ex_src = {5'd0, 5'd1};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd_sel", {28'd0, fwd_sel}, 32'd0);
    chk("reset_stat_fwd", {28'd0, stat_fwd}, 32'd0);
    chk("reset_stat_stall", {28'd0, stat_stall}, 32'd0);

    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    // Table vectors: stall checked in-cycle, fwd_sel after the edge.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      ex_src = vecs[k].ex_src; id_src = vecs[k].id_src; ex_rd = vecs[k].ex_rd;
      ex_memread = vecs[k].memread; mem_rd = vecs[k].mem_rd; mem_regwrite = vecs[k].mem_we;
      wb_rd = vecs[k].wb_rd; wb_regwrite = vecs[k].wb_we;
      #1;
      chk($sformatf("vec%0d_stall", k), {31'd0, stall}, {31'd0, vecs[k].exp_stall});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_fwd_sel", k), {28'd0, fwd_sel}, {28'd0, vecs[k].exp_fwd});
    end

    // Load-use held for 3 cycles: RUN, BUBBLE, RUN -> 1, 0, 1.
    @(negedge clk);
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd4; id_src = {5'd4, 5'd0};
    #1;
    chk("hold_stall_c0", {31'd0, stall}, 32'd1);
    @(negedge clk); #1;
    chk("hold_stall_c1", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("hold_stall_c2", {31'd0, stall}, 32'd1);

    // Now in BUBBLE: pulse reset with hazard still present.
    @(negedge clk); #1;
    chk("bubble_before_reset", {31'd0, stall}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("stall_during_reset", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("stall_after_reset", {31'd0, stall}, 32'd1);

    // No load -> no stall.
    ex_memread = 1'b0;
    #1;
    chk("no_memread_stall", {31'd0, stall}, 32'd0);

    // Counters: clean reset, then 20 forward cycles saturate a 4-bit counter.
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("stats_cleared_fwd", {28'd0, stat_fwd}, 32'd0);
    chk("stats_cleared_stall", {28'd0, stat_stall}, 32'd0);
    mem_rd = 5'd1; mem_regwrite = 1'b1; ex_src = {5'd0, 5'd1};
    repeat (20) @(posedge clk);
    #1;
    chk("stat_fwd_saturate", {28'd0, stat_fwd}, {28'd0, EXP_SAT_FWD});
    repeat (3) @(posedge clk);
    #1;
    chk("stat_fwd_hold", {28'd0, stat_fwd}, {28'd0, EXP_SAT_FWD});
    chk("stat_stall_none", {28'd0, stat_stall}, 32'd0);

    // One stall cycle from a single load.
    @(negedge clk);
    ex_memread = 1'b1; ex_rd = 5'd4; id_src = {5'd4, 5'd0};
    @(negedge clk);
    ex_memread = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stat_stall_one", {28'd0, stat_stall}, {28'd0, EXP_ONE_STALL});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
